// File: rtl/audio_i2s_dac_tx.sv
// audio_i2s_dac_tx: I2S DAC transmitter. It double-buffers samples into a frame register,
// signals sample requests to the synth, and counts underruns.
module audio_i2s_dac_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 4
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_data,
    input  logic                     enable,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     sample_req,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt
);
    localparam int FW  = 2 * SLOT_BITS;
    localparam int BW  = $clog2(FW);
    localparam int DW  = $clog2(BCLK_DIV);
    localparam int PAD = SLOT_BITS - AUD_BIT_DEPTH;

    logic [DW-1:0]            div_cnt;
    logic [BW-1:0]            bit_cnt, bit_nxt;
    logic [AUD_BIT_DEPTH-1:0] hold_l, hold_r;
    logic [FW-1:0]            frame;
    logic [SLOT_BITS-1:0]     slot_l, slot_r;
    logic                     fresh, tc, fall, cap;

    assign tc      = div_cnt == DW'(BCLK_DIV - 1);
    assign fall    = enable && tc && AUD_BCLK;
    assign cap     = fall && bit_cnt == BW'(FW - 1);
    assign bit_nxt = bit_cnt == BW'(FW - 1) ? '0 : bit_cnt + 1'b1;
    assign slot_l  = SLOT_BITS'(hold_l) << PAD;
    assign slot_r  = SLOT_BITS'(hold_r) << PAD;

    always_ff @(posedge AUDIO_CLK or posedge reset_data) begin
        if (reset_data) begin
            div_cnt      <= '0;
            bit_cnt      <= BW'(FW - 1);
            hold_l       <= '0;
            hold_r       <= '0;
            frame        <= '0;
            fresh        <= 1'b0;
            sample_req   <= 1'b0;
            AUD_BCLK     <= 1'b0;
            AUD_DACLRCK  <= 1'b0;
            AUD_DACDAT   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            if (sample_valid) begin
                hold_l <= lsound_in;
                hold_r <= rsound_in;
            end
            // a write coinciding with a capture survives into the next frame
            fresh <= sample_valid || (fresh && !cap);
            if (!enable) begin
                div_cnt     <= '0;
                bit_cnt     <= BW'(FW - 1);
                AUD_BCLK    <= 1'b0;
                AUD_DACLRCK <= 1'b0;
                AUD_DACDAT  <= 1'b0;
            end else begin
                div_cnt <= tc ? '0 : div_cnt + 1'b1;
                if (tc)
                    AUD_BCLK <= !AUD_BCLK;
                if (fall) begin
                    bit_cnt     <= bit_nxt;
                    AUD_DACLRCK <= bit_nxt >= BW'(SLOT_BITS);
                    // old bit_cnt is k-1, giving the one-BCLK I2S delay; k=0 reads the old frame's LSB
                    AUD_DACDAT  <= frame[BW'(FW - 1) - bit_cnt];
                end
                if (cap) begin
                    frame      <= {slot_l, slot_r};
                    sample_req <= 1'b1;
                    if (!fresh) begin
                        underrun <= 1'b1;
                        if (underrun_cnt != 8'hFF)
                            underrun_cnt <= underrun_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_i2s_dac_tx.sv
// tb_audio_i2s_dac_tx: directed checks of I2S timing, framing, underrun handling, enable and reset.
module tb_audio_i2s_dac_tx;
    logic        AUDIO_CLK;
    logic        reset_data, enable, sample_valid;
    logic [23:0] l_in, r_in;
    logic        sample_req, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, underrun;
    logic [7:0]  underrun_cnt;

    logic        en2, valid2;
    logic [1:0]  l2, r2;
    logic        req2, bclk2, lrck2, dat2, und2;
    logic [7:0]  cnt2;

    int tests, fails, cyc, base, bclk_bad;
    logic [63:0] dw, lw;
    int reqs, unds;

    localparam logic [63:0] FRAME_A = 64'hABCDEF00_12345600;
    localparam logic [63:0] FRAME_B = 64'h80000100_7FFFFF00;
    localparam logic [63:0] FRAME_C = 64'h00F00F00_C0000300;
    localparam logic [63:0] LRCK_W  = 64'h00000001_FFFFFFFE;

    audio_i2s_dac_tx dut (
        .AUDIO_CLK(AUDIO_CLK), .reset_data(reset_data), .enable(enable),
        .lsound_in(l_in), .rsound_in(r_in), .sample_valid(sample_valid),
        .sample_req(sample_req), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT(AUD_DACDAT), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    // short-frame instance so counter saturation is reachable quickly
    audio_i2s_dac_tx #(.AUD_BIT_DEPTH(2), .SLOT_BITS(2), .BCLK_DIV(2)) u_small (
        .AUDIO_CLK(AUDIO_CLK), .reset_data(reset_data), .enable(en2),
        .lsound_in(l2), .rsound_in(r2), .sample_valid(valid2),
        .sample_req(req2), .AUD_BCLK(bclk2), .AUD_DACLRCK(lrck2),
        .AUD_DACDAT(dat2), .underrun(und2), .underrun_cnt(cnt2)
    );

    initial AUDIO_CLK = 1'b0;
    always #5 AUDIO_CLK = ~AUDIO_CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge AUDIO_CLK);
        @(negedge AUDIO_CLK);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // runs one 512-cycle frame starting at a capture cycle, collecting one data/lrck bit per BCLK
    task automatic run_frame(output logic [63:0] d, output logic [63:0] l, output int rq, output int un);
        d = '0; l = '0; rq = 0; un = 0;
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (AUD_BCLK !== 1'(((cyc - base) / 4) % 2)) bclk_bad++;
            rq += int'(sample_req);
            un += int'(underrun);
            if (i % 8 == 0) begin
                d = {d[62:0], AUD_DACDAT};
                l = {l[62:0], AUD_DACLRCK};
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; base = 0; bclk_bad = 0;
        reset_data = 1'b1; enable = 1'b0; sample_valid = 1'b0; l_in = '0; r_in = '0;
        en2 = 1'b0; valid2 = 1'b0; l2 = '0; r2 = '0;
        ticks(2);
        check("rst_outs", {60'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req}, 64'd0);
        check("rst_cnt", {55'd0, underrun, underrun_cnt}, 64'd0);

        reset_data = 1'b0; enable = 1'b1; en2 = 1'b1; base = cyc;
        sample_valid = 1'b1; l_in = 24'hABCDEF; r_in = 24'h123456;
        tick();
        sample_valid = 1'b0;
        ticks(2);
        check("bclk_c3", 64'(AUD_BCLK), 64'd0);
        tick();
        check("bclk_c4", 64'(AUD_BCLK), 64'd1);
        ticks(3);
        check("req_c7", {62'd0, sample_req, AUD_BCLK}, 64'd1);
        tick();
        check("cap_c8", {60'd0, AUD_BCLK, AUD_DACLRCK, sample_req, underrun}, 64'd2);

        run_frame(dw, lw, reqs, unds);
        check("frame1_dat", dw, FRAME_A);
        check("frame1_lrck", lw, LRCK_W);
        check("frame1_reqs", 64'(reqs), 64'd1);
        check("frame1_und", 64'(unds), 64'd1);
        check("und_cnt1", 64'(underrun_cnt), 64'd1);
        check("small_cnt33", 64'(cnt2), 64'd33);
        run_frame(dw, lw, reqs, unds);
        check("frame2_dat", dw, FRAME_A);
        run_frame(dw, lw, reqs, unds);
        check("frame3_dat", dw, FRAME_A);
        check("und_cnt3", 64'(underrun_cnt), 64'd3);

        ticks(511);
        sample_valid = 1'b1; l_in = 24'h800001; r_in = 24'h7FFFFF;
        tick();
        sample_valid = 1'b0;
        check("coinc_cap", {61'd0, sample_req, underrun, 1'b0}, 64'd6);
        check("coinc_cnt", 64'(underrun_cnt), 64'd4);
        run_frame(dw, lw, reqs, unds);
        check("coinc_old_dat", dw, FRAME_A);
        check("coinc_next_und", 64'(unds), 64'd0);
        check("coinc_cnt_hold", 64'(underrun_cnt), 64'd4);
        run_frame(dw, lw, reqs, unds);
        check("coinc_new_dat", dw, FRAME_B);
        check("und_cnt5", 64'(underrun_cnt), 64'd5);

        ticks(332);
        check("pre_dis", {61'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}, 64'd7);
        enable = 1'b0;
        tick();
        check("dis_outs", {61'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}, 64'd0);
        sample_valid = 1'b1; l_in = 24'h00F00F; r_in = 24'hC00003;
        tick();
        sample_valid = 1'b0;
        ticks(3);
        check("dis_idle", {60'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req}, 64'd0);
        enable = 1'b1; base = cyc;
        ticks(7);
        check("reen_c7", 64'(sample_req), 64'd0);
        tick();
        check("reen_c8", {62'd0, sample_req, underrun}, 64'd2);
        run_frame(dw, lw, reqs, unds);
        check("reen_dat", dw, FRAME_C);
        check("reen_lrck", lw, LRCK_W);
        check("und_cnt6", 64'(underrun_cnt), 64'd6);
        check("bclk_shape", 64'(bclk_bad), 64'd0);

        ticks(1000);
        check("small_sat", 64'(cnt2), 64'd255);

        ticks(3);
        #2 reset_data = 1'b1;
        #1;
        check("arst_outs", {59'd0, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req, underrun}, 64'd0);
        check("arst_cnt", {48'd0, underrun_cnt, cnt2}, 64'd0);
        @(negedge AUDIO_CLK);
        reset_data = 1'b0; base = cyc;
        ticks(7);
        check("post_rst_c7", {62'd0, sample_req, AUD_BCLK}, 64'd1);
        tick();
        check("post_rst_c8", {62'd0, sample_req, underrun}, 64'd3);
        check("post_rst_cnt", 64'(underrun_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
